invader_formation: RTL
======================

# invader_formation

Parametrised enemy-formation engine for the Space Invaders game datapath. It owns the enemy grid state: alive bitmap, anchor position, sweep direction and move-rate divider. It serialises three kinds of work: formation moves on frame ticks, bullet collision queries, and a per-cell draw stream for the sprite drawer. It generalises the fixed 9x2 grid to ROWS x COLS, adds valid/ready draw and req/ack hit handshakes, and adds an optional speed-up as enemies die.

## Interface
Parameters:
- ROWS, 2, grid rows (y direction)
- COLS, 9, grid columns (x direction)
- X_W, 9, x coordinate width; Y_W, 8, y coordinate width
- PITCH_X, 28, PITCH_Y, 25: cell pitch in pixels
- SPR_W, 20, SPR_H, 16: sprite hit box size
- X0, 8, Y0, 10: anchor reset position
- X_MIN, 8, X_MAX, 60: anchor x sweep limits, inclusive
- Y_STEP, 20: anchor y increment on edge bounce
- Y_LIMIT, 200: invasion line
- DIV, 4: frame ticks per move, must be at least 1

Ports (N = ROWS*COLS, CW = $clog2(N+1)):
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- tick  in  1  one-cycle frame pulse
- hit_req  in  1  collision query; held high until hit_ack
- hit_x  in  X_W  bullet x; hit_y  in  Y_W  bullet y. Both stable while hit_req is high.
- hit_ack  out  1  one-cycle query completion
- hit_kill  out  1  valid with hit_ack: 1 = an enemy was killed
- draw_start  in  1  request one draw pass
- draw_valid  out  1  draw beat valid; draw_ready  in  1  drawer accepts the beat
- draw_x  out  X_W, draw_y  out  Y_W: cell top-left corner
- draw_alive  out  1  0 = drawer paints the cell black
- draw_last  out  1  final beat of the pass
- alive_count  out  CW  live enemies
- all_dead  out  1  alive_count == 0
- reached_limit  out  1  sticky invasion flag
- busy  out  1  state != IDLE

## Operation
- Cells are indexed row-major: idx = r*COLS + c. Cell origin is cx = anchor_x + c*PITCH_X, cy = anchor_y + r*PITCH_Y. All arithmetic is unsigned at X_W/Y_W width. Parameters must keep every cx+SPR_W and cy+SPR_H inside range; no wrap handling.
- FSM states: IDLE, MOVE, HIT, DRAW.
- tick in any state sets tick_pend. tick_pend clears on entry to MOVE unless a new tick arrives in the same cycle.
- IDLE priority: hit_req > tick_pend (go to MOVE) > draw_start. A draw_start that is not taken is dropped.
- MOVE (one cycle):
  - If div_cnt != thr-1: div_cnt increments, no move.
  - Otherwise div_cnt <= 0 and the formation steps. Moving right at anchor_x == X_MAX, or left at X_MIN: flip direction, anchor_y += Y_STEP, anchor_x unchanged. Else anchor_x moves ±1.
  - reached_limit is set when the new anchor_y + (ROWS-1)*PITCH_Y >= Y_LIMIT.
  - thr = DIV.
- HIT: scans one cell per cycle, index k = 0..N-1.
  - A cell matches when it is alive AND cx <= hit_x <= cx+SPR_W-1 AND cy <= hit_y <= cy+SPR_H-1.
  - The first match stops the scan. Its alive bit is cleared and alive_count decrements in the ack cycle.
  - At most one kill per query.
- DRAW: emits N beats in idx order, dead cells included with draw_alive = 0. Beats are held stable while draw_valid && !draw_ready. draw_last is asserted on idx N-1. The acceptance of the last beat returns the FSM to IDLE.
- hit_req arriving during DRAW or MOVE waits; it is not dropped.

## Timing
- Reset values:
  - state IDLE; anchor (X0, Y0); direction right; all alive; alive_count = N; div_cnt = 0; tick_pend = 0.
  - Outputs: hit_ack, hit_kill, draw_valid, draw_last, reached_limit, all_dead, busy all 0.
  - Reset mid-pass aborts it immediately.
- Hit latency: hit_req sampled in IDLE at cycle 0. Cell k is checked in cycle k+1. hit_ack is registered in cycle m+2, where m is the deciding index (N-1 on a miss).
- Requester must drop hit_req in the cycle after hit_ack. A still-high hit_req is treated as a new query.
- First draw beat is valid 1 cycle after draw_start is taken. Throughput is 1 beat per cycle with draw_ready held high.
- alive_count, all_dead and reached_limit update in the same edge as the causing event.

## Configuration
- FORMATION_SPEEDUP_EN defined: thr = 1 when alive_count <= N/4 (floor); thr = max(1, DIV/2) when alive_count <= N/2; otherwise thr = DIV. div_cnt is reset to 0 if it is >= the new thr.
- Not defined: thr = DIV always.

## Test plan
- Reset, then draw_start with draw_ready=1 -> 18 beats, one per cycle:
  - first (8,10) alive
  - idx1 (36,10)
  - last (232,35) with draw_last=1
  - busy low the cycle after.
- hit (40,20) -> hit_ack at cycle 3 with hit_kill=1; alive_count 17. Redraw shows idx1 draw_alive=0. The same query repeated -> miss, ack at cycle 19.
- 4 ticks -> anchor_x 9. 208 ticks total -> anchor_x 60. 4 more -> anchor (60,30), direction left.
- Drive moves until anchor_y = 190 -> reached_limit = 1; it stays 1 after further moves.
- draw_ready toggled 0/1 during a pass -> no beat lost or duplicated. A tick during DRAW runs MOVE right after the pass; a hit_req during DRAW is acked after the pass.
- With FORMATION_SPEEDUP_EN: kill 14 enemies (alive 4) -> the anchor moves on every tick. Without the macro -> one move per 4 ticks.

Source files
------------

// File: rtl/invader_formation_if.sv
`default_nettype none
// ============================================================================
// Module   : invader_formation_if
// Summary  : Hit-query (req/ack) and draw-stream (valid/ready) bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface invader_formation_if #(
  parameter int X_W = 9,
  parameter int Y_W = 8
) ();
  logic           hit_req;
  logic [X_W-1:0] hit_x;
  logic [Y_W-1:0] hit_y;
  logic           hit_ack;
  logic           hit_kill;
  logic           draw_start;
  logic           draw_valid;
  logic           draw_ready;
  logic [X_W-1:0] draw_x;
  logic [Y_W-1:0] draw_y;
  logic           draw_alive;
  logic           draw_last;

  modport master (
    output hit_req, hit_x, hit_y, draw_start, draw_ready,
    input  hit_ack, hit_kill, draw_valid, draw_x, draw_y, draw_alive, draw_last
  );

  modport slave (
    input  hit_req, hit_x, hit_y, draw_start, draw_ready,
    output hit_ack, hit_kill, draw_valid, draw_x, draw_y, draw_alive, draw_last
  );
endinterface
`default_nettype wire

// File: rtl/invader_formation.sv
`default_nettype none
// ============================================================================
// Module   : invader_formation
// Summary  : ROWS x COLS enemy formation engine: frame moves, bullet hit scan,
//            per-cell draw stream. FORMATION_SPEEDUP_EN shortens the move
//            divider as enemies die.
// Revision : 1.0 - initial release
// ============================================================================
module invader_formation #(
  parameter int ROWS    = 2,
  parameter int COLS    = 9,
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int PITCH_X = 28,
  parameter int PITCH_Y = 25,
  parameter int SPR_W   = 20,
  parameter int SPR_H   = 16,
  parameter int X0      = 8,
  parameter int Y0      = 10,
  parameter int X_MIN   = 8,
  parameter int X_MAX   = 60,
  parameter int Y_STEP  = 20,
  parameter int Y_LIMIT = 200,
  parameter int DIV     = 4
) (
  input  wire                             clk,
  input  wire                             resetn,
  input  wire                             tick,
  invader_formation_if.slave              bus,
  output logic [$clog2(ROWS*COLS+1)-1:0]  alive_count,
  output logic                            all_dead,
  output logic                            reached_limit,
  output logic                            busy
);
  localparam int c_N   = ROWS * COLS;
  localparam int c_CW  = $clog2(c_N + 1);
  localparam int c_IW  = (c_N > 1) ? $clog2(c_N) : 1;
  localparam int c_RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int c_DW  = $clog2(DIV + 1);

  localparam logic [X_W-1:0] c_PITCH_X  = X_W'(PITCH_X);
  localparam logic [Y_W-1:0] c_PITCH_Y  = Y_W'(PITCH_Y);
  localparam logic [X_W-1:0] c_SPR_W_M1 = X_W'(SPR_W - 1);
  localparam logic [Y_W-1:0] c_SPR_H_M1 = Y_W'(SPR_H - 1);
  localparam logic [X_W-1:0] c_X_MIN    = X_W'(X_MIN);
  localparam logic [X_W-1:0] c_X_MAX    = X_W'(X_MAX);
  localparam logic [Y_W-1:0] c_Y_STEP   = Y_W'(Y_STEP);
  localparam logic [Y_W-1:0] c_ROW_SPAN = Y_W'((ROWS - 1) * PITCH_Y);
  localparam logic [Y_W-1:0] c_Y_LIMIT  = Y_W'(Y_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_HIT  = 2'd2,
    S_DRAW = 2'd3
  } state_t;

  state_t            r_state, w_state_next;
  logic [c_N-1:0]    r_alive;
  logic [c_CW-1:0]   r_alive_count;
  logic [X_W-1:0]    r_anchor_x;
  logic [Y_W-1:0]    r_anchor_y;
  logic              r_dir_right;
  logic [c_DW-1:0]   r_div_cnt;
  logic              r_tick_pend;
  logic              r_reached;
  logic [c_IW-1:0]   r_idx;
  logic [c_RW-1:0]   r_row;
  logic [c_CLW-1:0]  r_col;

  logic [X_W-1:0]    w_cx;
  logic [Y_W-1:0]    w_cy;
  logic [Y_W-1:0]    w_new_ay;
  logic [c_DW-1:0]   w_thr;
  logic              w_match, w_last_idx;
  logic              w_enter_move, w_start_scan, w_start_draw, w_hit_done, w_advance;

  // Origin of the cell under the scan/draw pointer
  assign w_cx       = r_anchor_x + X_W'(r_col) * c_PITCH_X;
  assign w_cy       = r_anchor_y + Y_W'(r_row) * c_PITCH_Y;
  assign w_new_ay   = r_anchor_y + c_Y_STEP;
  assign w_last_idx = (r_idx == c_IW'(c_N - 1));
  assign w_match    = r_alive[r_idx]
                    && (bus.hit_x >= w_cx) && (bus.hit_x <= w_cx + c_SPR_W_M1)
                    && (bus.hit_y >= w_cy) && (bus.hit_y <= w_cy + c_SPR_H_M1);

`ifdef FORMATION_SPEEDUP_EN
  localparam int c_HALF = (DIV / 2 > 1) ? DIV / 2 : 1;
  always_comb begin
    if (r_alive_count <= c_CW'(c_N / 4))      w_thr = c_DW'(1);
    else if (r_alive_count <= c_CW'(c_N / 2)) w_thr = c_DW'(c_HALF);
    else                                      w_thr = c_DW'(DIV);
  end
`else
  assign w_thr = c_DW'(DIV);
`endif

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_enter_move = 1'b0;
    w_start_scan = 1'b0;
    w_start_draw = 1'b0;
    w_hit_done   = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A request still high during its own ack cycle is the old query
        if (bus.hit_req && !bus.hit_ack) begin
          w_state_next = S_HIT;
          w_start_scan = 1'b1;
        end else if (r_tick_pend) begin
          w_state_next = S_MOVE;
          w_enter_move = 1'b1;
        end else if (bus.draw_start) begin
          w_state_next = S_DRAW;
          w_start_draw = 1'b1;
        end
      end
      S_MOVE: w_state_next = S_IDLE;
      S_HIT: begin
        if (w_match || w_last_idx) begin
          w_hit_done   = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_advance = 1'b1;
        end
      end
      S_DRAW: begin
        if (bus.draw_ready) begin
          if (w_last_idx) w_state_next = S_IDLE;
          else            w_advance    = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_alive       <= '1;
      r_alive_count <= c_CW'(c_N);
      r_anchor_x    <= X_W'(X0);
      r_anchor_y    <= Y_W'(Y0);
      r_dir_right   <= 1'b1;
      r_div_cnt     <= '0;
      r_tick_pend   <= 1'b0;
      r_reached     <= 1'b0;
      r_idx         <= '0;
      r_row         <= '0;
      r_col         <= '0;
      bus.hit_ack   <= 1'b0;
      bus.hit_kill  <= 1'b0;
    end else begin
      r_tick_pend  <= tick | (r_tick_pend & ~w_enter_move);
      bus.hit_ack  <= w_hit_done;
      bus.hit_kill <= w_hit_done & w_match;

      if (w_start_scan || w_start_draw) begin
        r_idx <= '0;
        r_row <= '0;
        r_col <= '0;
      end else if (w_advance) begin
        r_idx <= r_idx + 1'b1;
        if (r_col == c_CLW'(COLS - 1)) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      if (w_hit_done && w_match) begin
        r_alive[r_idx] <= 1'b0;
        r_alive_count  <= r_alive_count - 1'b1;
      end

      if (r_state == S_MOVE) begin
        if (r_div_cnt < w_thr - 1'b1) begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end else begin
          r_div_cnt <= '0;
          if ((r_dir_right && r_anchor_x == c_X_MAX) || (!r_dir_right && r_anchor_x == c_X_MIN)) begin
            r_dir_right <= ~r_dir_right;
            r_anchor_y  <= w_new_ay;
            if (w_new_ay + c_ROW_SPAN >= c_Y_LIMIT) r_reached <= 1'b1;
          end else if (r_dir_right) begin
            r_anchor_x <= r_anchor_x + 1'b1;
          end else begin
            r_anchor_x <= r_anchor_x - 1'b1;
          end
        end
      end else if (r_div_cnt >= w_thr) begin
        // Threshold dropped below the running count after a kill
        r_div_cnt <= '0;
      end
    end
  end

  assign bus.draw_valid = (r_state == S_DRAW);
  assign bus.draw_x     = w_cx;
  assign bus.draw_y     = w_cy;
  assign bus.draw_alive = r_alive[r_idx];
  assign bus.draw_last  = (r_state == S_DRAW) && w_last_idx;

  assign alive_count   = r_alive_count;
  assign all_dead      = (r_alive_count == '0);
  assign reached_limit = r_reached;
  assign busy          = (r_state != S_IDLE);
endmodule
`default_nettype wire
